// File: rtl/reset_gen_if.sv
// Request/sequencer inputs and reset/busy outputs of the reset generator.
// The generator itself connects through the slave modport.
interface reset_gen_if;
  logic button_n;
  logic soft_req;
  logic M1;
  logic T1;
  logic reset_in;
  logic busy;

  modport slave  (input  button_n, soft_req, M1, T1, output reset_in, busy);
  modport master (output button_n, soft_req, M1, T1, input  reset_in, busy);
endinterface

// File: rtl/reset_gen.sv
// CPU reset generator: power-on stretch, debounced push-button hard reset and a
// soft reset aligned to the sequencer's M1/T1 slot, all driving a registered reset_in.
module reset_gen #(
  parameter int POR_CYCLES   = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int DEBOUNCE     = 8
) (
  input  logic       clk,
  input  logic       fpga_reset,
  reset_gen_if.slave bus
);
  localparam int PULSE_EFF = (PULSE_CYCLES < 3) ? 3 : PULSE_CYCLES;
  localparam int CNT_MAX   = (POR_CYCLES > PULSE_EFF) ? POR_CYCLES : PULSE_EFF;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DB_W      = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_EFF - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_IDLE       = 3'd1,
    ST_HARD       = 3'd2,
    ST_HOLD       = 3'd3,
    ST_SOFT_WAIT  = 3'd4,
    ST_SOFT_PULSE = 3'd5
  } state_e;

  // Power-up values equal the reset values so reset_in is high from the first edge.
  logic             sync1_q    = 1'b1;
  logic             sync2_q    = 1'b1;
  logic [DB_W-1:0]  db_cnt_q   = '0;
  logic             pressed_q  = 1'b0;
  state_e           state_q    = ST_POR;
  logic [CNT_W-1:0] cnt_q      = '0;
  logic             reset_in_q = 1'b1;
  logic             busy_q     = 1'b1;

  logic             sync1_d;
  logic             sync2_d;
  logic [DB_W-1:0]  db_cnt_d;
  logic             pressed_d;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             reset_in_d;
  logic             busy_d;
  logic             btn_low;

  assign btn_low = ~sync2_q;

  always_comb begin
    sync1_d   = bus.button_n;
    sync2_d   = sync1_q;
    db_cnt_d  = '0;
    pressed_d = pressed_q;
    // A sample disagreeing with the current level extends the run; agreement restarts it.
    if (btn_low != pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = ~pressed_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d  = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_IDLE: begin
        if (pressed_q)         state_d = ST_HARD;
        else if (bus.soft_req) state_d = ST_SOFT_WAIT;
        else                   state_d = ST_IDLE;
      end
      ST_HARD: begin
        if (cnt_q == PULSE_LAST) state_d = pressed_q ? ST_HOLD : ST_IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_HOLD: begin
        if (pressed_q) state_d = ST_HOLD;
        else           state_d = ST_IDLE;
      end
      ST_SOFT_WAIT: begin
        if (pressed_q)              state_d = ST_HARD;
        else if (bus.M1 && bus.T1)  state_d = ST_SOFT_PULSE;
        else                        state_d = ST_SOFT_WAIT;
      end
      ST_SOFT_PULSE: begin
        if (pressed_q) state_d = ST_HARD;
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_POR;
    endcase
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_d;
    reset_in_d = (state_d inside {ST_POR, ST_HARD, ST_HOLD, ST_SOFT_PULSE});
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (fpga_reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_cnt_q   <= '0;
      pressed_q  <= 1'b0;
      state_q    <= ST_POR;
      cnt_q      <= '0;
      reset_in_q <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      pressed_q  <= pressed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reset_in_q <= reset_in_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.reset_in = reset_in_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_reset_gen.sv
// Directed and randomized checks of reset_gen against a countdown-style
// behavioural model of the reset rules.
module tb_reset_gen;
  localparam int POR_CYCLES   = 16;
  localparam int PULSE_CYCLES = 4;
  localparam int DEBOUNCE     = 8;

  logic clk = 1'b0;
  logic fpga_reset;
  int   total = 0;
  int   bad   = 0;

  reset_gen_if bus();

  reset_gen #(
    .POR_CYCLES  (POR_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES),
    .DEBOUNCE    (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .fpga_reset(fpga_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Model: synchronizer copies, a window of recent "pressed" samples, and remaining-time counters.
  bit m_s1 = 1'b1;
  bit m_s2 = 1'b1;
  bit m_pressed = 1'b0;
  bit hist[$];
  int por_left = POR_CYCLES;
  int hard_left = 0;
  bit holding = 1'b0;
  bit waiting = 1'b0;
  bit pulsing = 1'b0;
  bit exp_reset = 1'b1;
  bit exp_busy = 1'b1;

  task automatic model_edge(input bit fr, input bit bn, input bit sr, input bit m1, input bit t1);
    bit old_p;
    bit all_opp;
    old_p = m_pressed;
    if (fr) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; hist.delete();
    end else begin
      hist.push_back(!m_s2);
      if (hist.size() > DEBOUNCE) void'(hist.pop_front());
      all_opp = (hist.size() == DEBOUNCE);
      foreach (hist[i]) if (hist[i] == m_pressed) all_opp = 1'b0;
      if (all_opp) m_pressed = !m_pressed;
      m_s2 = m_s1;
      m_s1 = bn;
    end
    if (fr) begin
      por_left = POR_CYCLES; hard_left = 0; holding = 0; waiting = 0; pulsing = 0;
    end else if (por_left != 0) begin
      por_left--;
    end else if (hard_left != 0) begin
      hard_left--;
      if (hard_left == 0) holding = old_p;
    end else if (holding) begin
      holding = old_p;
    end else if (old_p) begin
      hard_left = PULSE_CYCLES; waiting = 0; pulsing = 0;
    end else if (pulsing) begin
      pulsing = 0;
    end else if (waiting) begin
      if (m1 && t1) begin waiting = 0; pulsing = 1; end
    end else if (sr) begin
      waiting = 1;
    end
    exp_reset = (por_left != 0) || (hard_left != 0) || holding || pulsing;
    exp_busy  = exp_reset || waiting;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input bit fr, input bit bn, input bit sr, input bit m1, input bit t1, input string tag);
    fpga_reset   = fr;
    bus.button_n = bn;
    bus.soft_req = sr;
    bus.M1       = m1;
    bus.T1       = t1;
    @(posedge clk);
    model_edge(fr, bn, sr, m1, t1);
    @(negedge clk);
    check({tag, ".reset_in"}, {31'd0, bus.reset_in}, {31'd0, exp_reset});
    check({tag, ".busy"},     {31'd0, bus.busy},     {31'd0, exp_busy});
  endtask

  initial begin
    int n;
    int rise;
    bit bn_r;
    bn_r = 1'b1;

    // Power-on: two reset cycles, then exactly POR_CYCLES high samples.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "por_hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "por_hold");
    check("reset_state.reset_in", {31'd0, bus.reset_in}, 32'd1);
    check("reset_state.busy",     {31'd0, bus.busy},     32'd1);
    n = int'(bus.reset_in);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "por");
      n += int'(bus.reset_in);
    end
    check("por_width", n, 32'd16);

    // Ten-cycle press: rise 2+8 cycles after first low sample, width follows press length.
    rise = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (i >= 10), 1'b0, 1'b0, 1'b0, "press10");
      if (bus.reset_in) begin
        if (rise < 0) rise = i;
        n++;
      end
    end
    check("press10_rise", rise, 32'd10);
    check("press10_width", n, 32'd10);

    // Forty-cycle press: high until release has been debounced.
    rise = -1; n = 0;
    for (int i = 0; i < 70; i++) begin
      step(1'b0, (i >= 40), 1'b0, 1'b0, 1'b0, "press40");
      if (bus.reset_in) begin
        if (rise < 0) rise = i;
        n++;
      end
    end
    check("press40_rise", rise, 32'd10);
    check("press40_width", n, 32'd40);

    // Five-cycle glitch never reaches the debounced level.
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, (i >= 5), 1'b0, 1'b0, 1'b0, "glitch5");
      n += int'(bus.reset_in);
    end
    check("glitch_high_cycles", n, 32'd0);

    // Soft reset: single pulse right after M1&T1; a repeat request while waiting is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "soft_req");
    check("soft_wait_busy", {31'd0, bus.busy}, 32'd1);
    n = 0; rise = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, (i == 1), (i < 6), (i == 3), "soft");
      if (bus.reset_in) begin
        n++;
        rise = i;
      end
    end
    check("soft_pulse_width", n, 32'd1);
    check("soft_pulse_pos", rise, 32'd3);
    check("soft_no_queue_busy", {31'd0, bus.busy}, 32'd0);

    // Press and soft_req together: hard path wins; reset during HOLD restarts POR.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, (i == 10), 1'b0, 1'b0, "soft_vs_press");
      if (i == 10) check("press_wins", {31'd0, bus.reset_in}, 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hold_reset");
    n = int'(bus.reset_in);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "por_restart");
      n += int'(bus.reset_in);
    end
    check("por_restart_width", n, 32'd16);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) bn_r = !bn_r;
      step(($urandom_range(299) == 0), bn_r, ($urandom_range(7) == 0),
           ($urandom_range(1) == 1), ($urandom_range(2) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
